brick_field_collision: RTL and testbench

- Parametrised successor to the single-brick collision checker: owns a ROWS x COLS brick field.
- Geometry is derived from parameters; one alive bit is held per brick.
- On each `start` strobe (once per frame, after ball motion update) it scans the bricks sequentially, one per cycle. It reports at most one hit per scan, with brick index and bounce side, and clears the brick.
- Sits between the ball-motion block (consumes `hit`/`hit_side`) and the renderer/scoreboard (consume `alive_mask`/`bricks_left`).

---
 rtl/brick_pkg.sv | 29 ++
 rtl/brick_field_collision_if.sv | 38 +++
 rtl/brick_hit_test.sv | 38 +++
 rtl/brick_field_collision.sv | 167 ++++++++++++++++
 tb/tb_brick_field_collision.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/brick_pkg.sv
// Shared types and defaults for the brick field collision block.
package brick_pkg;

  localparam int DEF_ROWS    = 4;
  localparam int DEF_COLS    = 8;
  localparam int DEF_X0      = 32;
  localparam int DEF_Y0      = 40;
  localparam int DEF_BRICK_W = 64;
  localparam int DEF_BRICK_H = 16;
  localparam int DEF_GAP     = 8;
  localparam int DEF_H_SIZE  = 3;
  localparam int DEF_HP_INIT = 2;

  // Distance between the same edge of two neighbouring bricks on one axis.
  function automatic int brick_pitch(input int size, input int gap);
    return size + gap;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    REPORT,
    DONE
  } state_t;

  localparam logic SIDE_VERT = 1'b0;
  localparam logic SIDE_HORZ = 1'b1;

endpackage

// File: rtl/brick_field_collision_if.sv
// Control/status bundle between ball motion, renderer and the brick field.
interface brick_field_collision_if
  import brick_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS
);
  localparam int N     = ROWS * COLS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = $clog2(N + 1);

  logic             start;
  logic             restore;
  logic [9:0]       ball_x;
  logic [8:0]       ball_y;
  logic             busy;
  logic             done;
  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic             hit_side;
  logic             hit_kill;
  logic [N-1:0]     alive_mask;
  logic [CNT_W-1:0] bricks_left;
  logic             all_clear;

  modport master (
    output start, restore, ball_x, ball_y,
    input  busy, done, hit, hit_idx, hit_side, hit_kill,
           alive_mask, bricks_left, all_clear
  );

  modport slave (
    input  start, restore, ball_x, ball_y,
    output busy, done, hit, hit_idx, hit_side, hit_kill,
           alive_mask, bricks_left, all_clear
  );

endinterface

// File: rtl/brick_hit_test.sv
// Box test of the ball against one brick (margin-expanded) plus bounce-face choice.
module brick_hit_test
  import brick_pkg::*;
#(
  parameter int BRICK_W = DEF_BRICK_W,
  parameter int BRICK_H = DEF_BRICK_H,
  parameter int H_SIZE  = DEF_H_SIZE
) (
  input  logic [10:0] x1,
  input  logic [9:0]  y1,
  input  logic [9:0]  ball_x,
  input  logic [8:0]  ball_y,
  output logic        in_box,
  output logic        side
);
  localparam logic [10:0] H_X    = 11'(H_SIZE);
  localparam logic [10:0] X_SPAN = 11'(BRICK_W - 1 + H_SIZE);
  localparam logic [9:0]  H_Y    = 10'(H_SIZE);
  localparam logic [9:0]  Y_SPAN = 10'(BRICK_H - 1 + H_SIZE);

  logic [10:0] bx, x_lo, x_hi, dx;
  logic [9:0]  by, y_lo, y_hi, dy;

  always_comb begin
    bx   = {1'b0, ball_x};
    by   = {1'b0, ball_y};
    // Lower bounds clamp at 0; one extra bit keeps the upper bounds from wrapping.
    x_lo = (x1 >= H_X) ? x1 - H_X : '0;
    x_hi = x1 + X_SPAN;
    y_lo = (y1 >= H_Y) ? y1 - H_Y : '0;
    y_hi = y1 + Y_SPAN;
    in_box = (bx >= x_lo) && (bx <= x_hi) && (by >= y_lo) && (by <= y_hi);
    dx = (bx - x_lo < x_hi - bx) ? bx - x_lo : x_hi - bx;
    dy = (by - y_lo < y_hi - by) ? by - y_lo : y_hi - by;
    side = (in_box && (dx < {1'b0, dy})) ? SIDE_HORZ : SIDE_VERT;
  end

endmodule

// File: rtl/brick_field_collision.sv
// ROWS x COLS brick field: one brick tested per cycle, at most one hit per scan.
// Define BRICK_HP_EN to give each brick HP_INIT hit points before it dies.
module brick_field_collision
  import brick_pkg::*;
#(
  parameter int ROWS    = DEF_ROWS,
  parameter int COLS    = DEF_COLS,
  parameter int X0      = DEF_X0,
  parameter int Y0      = DEF_Y0,
  parameter int BRICK_W = DEF_BRICK_W,
  parameter int BRICK_H = DEF_BRICK_H,
  parameter int GAP     = DEF_GAP,
  parameter int H_SIZE  = DEF_H_SIZE,
  parameter int HP_INIT = DEF_HP_INIT
) (
  input logic                    clk,
  input logic                    reset,
  brick_field_collision_if.slave bus
);
  localparam int N     = ROWS * COLS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = $clog2(N + 1);
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N);
  localparam logic [10:0]      X_START  = 11'(X0);
  localparam logic [10:0]      X_STEP   = 11'(brick_pitch(BRICK_W, GAP));
  localparam logic [9:0]       Y_START  = 10'(Y0);
  localparam logic [9:0]       Y_STEP   = 10'(brick_pitch(BRICK_H, GAP));

  if (HP_INIT < 1) begin : g_hp_range
    $error("HP_INIT must be at least 1");
  end

  state_t state, state_next;

  logic [IDX_W-1:0] idx;
  logic [COL_W-1:0] col;
  logic [10:0]      x1;
  logic [9:0]       y1;
  logic [9:0]       ball_x_lat;
  logic [8:0]       ball_y_lat;
  logic [N-1:0]     alive;
  logic [CNT_W-1:0] left;
  logic [IDX_W-1:0] hit_idx;
  logic             hit_side;
  logic             hit_kill;
  logic             in_box, side_now, strike, kill_now;

  brick_hit_test #(
    .BRICK_W (BRICK_W),
    .BRICK_H (BRICK_H),
    .H_SIZE  (H_SIZE)
  ) u_hit_test (
    .x1     (x1),
    .y1     (y1),
    .ball_x (ball_x_lat),
    .ball_y (ball_y_lat),
    .in_box (in_box),
    .side   (side_now)
  );

  assign strike = (state == SCAN) && alive[idx] && in_box;

`ifdef BRICK_HP_EN
  localparam int HP_W = $clog2(HP_INIT + 1);
  localparam logic [HP_W-1:0] HP_FULL = HP_W'(HP_INIT);

  logic [N-1:0][HP_W-1:0] hp;

  assign kill_now = (hp[idx] == HP_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hp <= {N{HP_FULL}};
    end else if (bus.restore) begin
      hp <= {N{HP_FULL}};
    end else if (strike) begin
      hp[idx] <= hp[idx] - HP_W'(1);
    end
  end
`else
  assign kill_now = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = SCAN;
      SCAN: begin
        if (strike)                state_next = REPORT;
        else if (idx == IDX_LAST)  state_next = DONE;
      end
      REPORT:  state_next = IDLE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.restore) state_next = IDLE;
  end

  // Mask and count are committed on the SCAN->REPORT edge, so they are
  // already current while hit/done are presented.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx        <= '0;
      col        <= '0;
      x1         <= X_START;
      y1         <= Y_START;
      ball_x_lat <= '0;
      ball_y_lat <= '0;
      alive      <= '1;
      left       <= CNT_FULL;
      hit_idx    <= '0;
      hit_side   <= SIDE_VERT;
      hit_kill   <= 1'b0;
    end else if (bus.restore) begin
      alive <= '1;
      left  <= CNT_FULL;
    end else begin
      if (state == IDLE && bus.start) begin
        ball_x_lat <= bus.ball_x;
        ball_y_lat <= bus.ball_y;
        idx        <= '0;
        col        <= '0;
        x1         <= X_START;
        y1         <= Y_START;
      end else if (state == SCAN) begin
        idx <= idx + IDX_W'(1);
        if (col == COL_LAST) begin
          col <= '0;
          x1  <= X_START;
          y1  <= y1 + Y_STEP;
        end else begin
          col <= col + COL_W'(1);
          x1  <= x1 + X_STEP;
        end
      end
      if (strike) begin
        hit_idx  <= idx;
        hit_side <= side_now;
        hit_kill <= kill_now;
        if (kill_now) begin
          alive[idx] <= 1'b0;
          left       <= left - CNT_W'(1);
        end
      end
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == REPORT) || (state == DONE);
  assign bus.hit         = (state == REPORT);
  assign bus.hit_idx     = hit_idx;
  assign bus.hit_side    = hit_side;
  assign bus.hit_kill    = hit_kill;
  assign bus.alive_mask  = alive;
  assign bus.bricks_left = left;
  assign bus.all_clear   = (left == '0);

endmodule

// File: tb/tb_brick_field_collision.sv
// Directed and randomized scans of brick_field_collision against a geometric model.
module tb_brick_field_collision;
  localparam int ROWS    = 4;
  localparam int COLS    = 8;
  localparam int X0      = 32;
  localparam int Y0      = 40;
  localparam int BRICK_W = 64;
  localparam int BRICK_H = 16;
  localparam int GAP     = 8;
  localparam int H_SIZE  = 3;
  localparam int HP_INIT = 2;
  localparam int N       = ROWS * COLS;
`ifdef BRICK_HP_EN
  localparam int HP_START = HP_INIT;
`else
  localparam int HP_START = 1;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  brick_field_collision_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  brick_field_collision #(
    .ROWS(ROWS), .COLS(COLS), .X0(X0), .Y0(Y0), .BRICK_W(BRICK_W),
    .BRICK_H(BRICK_H), .GAP(GAP), .H_SIZE(H_SIZE), .HP_INIT(HP_INIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int passes = 0;
  int m_alive [N];
  int m_hp    [N];
  int m_left;
  int m_last_idx;
  bit m_last_side;
  bit m_last_kill;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void model_restore();
    for (int k = 0; k < N; k++) begin
      m_alive[k] = 1;
      m_hp[k]    = HP_START;
    end
    m_left = N;
  endfunction

  function automatic logic [N-1:0] model_mask();
    logic [N-1:0] m;
    for (int k = 0; k < N; k++) m[k] = (m_alive[k] != 0);
    return m;
  endfunction

  function automatic int cx(input int k);
    return X0 + (k % COLS) * (BRICK_W + GAP) + BRICK_W / 2;
  endfunction

  function automatic int cy(input int k);
    return Y0 + (k / COLS) * (BRICK_H + GAP) + BRICK_H / 2;
  endfunction

  // First live brick whose margin-expanded rectangle contains the ball.
  function automatic void model_find(input int bx, input int by,
                                     output bit h, output int k_hit, output bit side);
    h = 0; k_hit = 0; side = 0;
    for (int k = 0; k < N; k++) begin
      int x1, y1, xl, xh, yl, yh, dx, dy;
      if (h || m_alive[k] == 0) continue;
      x1 = X0 + (k % COLS) * (BRICK_W + GAP);
      y1 = Y0 + (k / COLS) * (BRICK_H + GAP);
      xl = (x1 - H_SIZE < 0) ? 0 : x1 - H_SIZE;
      yl = (y1 - H_SIZE < 0) ? 0 : y1 - H_SIZE;
      xh = x1 + BRICK_W - 1 + H_SIZE;
      yh = y1 + BRICK_H - 1 + H_SIZE;
      if (bx >= xl && bx <= xh && by >= yl && by <= yh) begin
        dx = (bx - xl < xh - bx) ? bx - xl : xh - bx;
        dy = (by - yl < yh - by) ? by - yl : yh - by;
        h = 1; k_hit = k; side = (dx < dy);
      end
    end
  endfunction

  task automatic check_idle_state(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_hit"}, bus.hit, 0);
    check({tag, "_hit_idx"}, bus.hit_idx, m_last_idx);
    check({tag, "_hit_side"}, bus.hit_side, m_last_side);
    check({tag, "_hit_kill"}, bus.hit_kill, m_last_kill);
    check({tag, "_mask"}, bus.alive_mask, model_mask());
    check({tag, "_left"}, bus.bricks_left, m_left);
    check({tag, "_all_clear"}, bus.all_clear, m_left == 0);
  endtask

  task automatic expect_quiet(input string tag);
    int pulses = 0;
    for (int i = 0; i < N + 3; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.hit === 1'b1) pulses++;
    end
    check({tag, "_no_done"}, pulses, 0);
    check_idle_state(tag);
  endtask

  task automatic run_scan(input int bx, input int by, input bit poke);
    bit eh, es, ek;
    int ei, cyc, lat;
    model_find(bx, by, eh, ei, es);
    ek = 0;
    if (eh) begin
      m_hp[ei]--;
      ek = (m_hp[ei] == 0);
    end
    lat  = eh ? ei + 2 : N + 1;
    poke = poke && (lat >= 5);
    @(negedge clk);
    bus.ball_x = 10'(bx);
    bus.ball_y = 9'(by);
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    check("busy_after_start", bus.busy, 1);
    while (bus.done !== 1'b1 && cyc <= N + 2) begin
      @(negedge clk);
      cyc++;
      bus.start = poke && (cyc == 3);
      if (cyc == 3) bus.ball_x = 10'($urandom_range(0, 1023));
    end
    check("done_cycle", cyc, lat);
    check("done_pulse", bus.done, 1);
    check("busy_in_done", bus.busy, 1);
    check("hit_pulse", bus.hit, eh);
    if (eh) begin
      m_last_idx  = ei;
      m_last_side = es;
      m_last_kill = ek;
      if (ek) begin
        m_alive[ei] = 0;
        m_left--;
      end
    end
    @(negedge clk);
    check_idle_state("after_scan");
  endtask

  task automatic pulse_restore(input bit with_start);
    @(negedge clk);
    bus.restore = 1'b1;
    bus.start   = with_start;
    bus.ball_x  = 10'(cx(0));
    bus.ball_y  = 9'(cy(0));
    @(negedge clk);
    bus.restore = 1'b0;
    bus.start   = 1'b0;
    model_restore();
    check("restore_mask", bus.alive_mask, model_mask());
    expect_quiet("restore");
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    bus.start = 1'b0;
    bus.restore = 1'b0;
    bus.ball_x = '0;
    bus.ball_y = '0;
    model_restore();
    m_last_idx = 0; m_last_side = 0; m_last_kill = 0;
    repeat (2) @(negedge clk);
    check_idle_state("reset");
    reset = 1'b1;

    // Corner hit on brick 0 (dx=11, dy=8 -> top/bottom face), then repeat.
    run_scan(40, 45, 0);
    run_scan(40, 45, 1);
    // Ball in the gap between column 0 and column 1.
    run_scan(100, 47, 0);
    pulse_restore(0);
    // Left-edge hit on brick 0 (dx=1 -> left/right face).
    run_scan(30, 50, 0);
    pulse_restore(0);
    // Two strikes on brick 2: HP build needs both to kill it.
    run_scan(200, 45, 0);
    run_scan(200, 45, 1);

    // Asynchronous reset in the middle of a long scan.
    @(negedge clk);
    bus.ball_x = 10'(cx(N - 1));
    bus.ball_y = 9'(cy(N - 1));
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    model_restore();
    m_last_idx = 0; m_last_side = 0; m_last_kill = 0;
    check_idle_state("mid_reset");
    @(negedge clk);
    reset = 1'b1;
    expect_quiet("post_reset");

    // Restore aborting a scan, then restore together with start.
    run_scan(cx(7), cy(7), 0);
    @(negedge clk);
    bus.ball_x = 10'(cx(20));
    bus.ball_y = 9'(cy(20));
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.restore = 1'b1;
    @(negedge clk);
    bus.restore = 1'b0;
    model_restore();
    expect_quiet("mid_restore");
    run_scan(cx(5), cy(5), 0);
    pulse_restore(1);

    // Random balls: half aimed near a brick edge, half anywhere.
    for (int i = 0; i < 60; i++) begin
      int k, bx, by;
      k = $urandom_range(0, N - 1);
      if ($urandom_range(0, 1) == 1) begin
        bx = X0 + (k % COLS) * (BRICK_W + GAP) - H_SIZE - 2
             + $urandom_range(0, BRICK_W + 2 * H_SIZE + 3);
        by = Y0 + (k / COLS) * (BRICK_H + GAP) - H_SIZE - 2
             + $urandom_range(0, BRICK_H + 2 * H_SIZE + 3);
      end else begin
        bx = $urandom_range(0, 1023);
        by = $urandom_range(0, 511);
      end
      run_scan(bx, by, (i % 5) == 0);
    end

    // Clear the whole field.
    pulse_restore(0);
    for (int k = 0; k < N; k++) begin
      while (m_alive[k] != 0) run_scan(cx(k), cy(k), 0);
    end
    check("field_all_clear", bus.all_clear, 1);
    check("field_left_zero", bus.bricks_left, 0);
    run_scan(cx(0), cy(0), 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
